// File: rtl/fetch_redirect_ctrl_if.sv
// Bundle between the branch resolver, commit/trap logic, fetch stage and the redirect controller.
interface fetch_redirect_ctrl_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned CNT_W  = 32
);
    logic              br_valid_i;
    logic              br_hit_i;
    logic              br_taken_i;
    logic [ADDR_W-1:0] br_pc_i;
    logic [ADDR_W-1:0] br_target_i;
    logic              xcpt_valid_i;
    logic [ADDR_W-1:0] xcpt_target_i;
    logic              if_req_inflight_i;
    logic              if_resp_valid_i;
    logic              pc_redirect_valid_o;
    logic [ADDR_W-1:0] pc_redirect_o;
    logic              flush_fetch_o;
    logic              drop_resp_o;
    logic              stall_decode_o;
    logic              bp_upd_valid_o;
    logic [ADDR_W-1:0] bp_upd_pc_o;
    logic [ADDR_W-1:0] bp_upd_target_o;
    logic              bp_upd_taken_o;
    logic [CNT_W-1:0]  mispredict_cnt_o;

    // Request side: drives resolutions, traps and fetch status
    modport master (
        output br_valid_i, br_hit_i, br_taken_i, br_pc_i, br_target_i,
               xcpt_valid_i, xcpt_target_i, if_req_inflight_i, if_resp_valid_i,
        input  pc_redirect_valid_o, pc_redirect_o, flush_fetch_o, drop_resp_o,
               stall_decode_o, bp_upd_valid_o, bp_upd_pc_o, bp_upd_target_o,
               bp_upd_taken_o, mispredict_cnt_o
    );

    // Controller side
    modport slave (
        input  br_valid_i, br_hit_i, br_taken_i, br_pc_i, br_target_i,
               xcpt_valid_i, xcpt_target_i, if_req_inflight_i, if_resp_valid_i,
        output pc_redirect_valid_o, pc_redirect_o, flush_fetch_o, drop_resp_o,
               stall_decode_o, bp_upd_valid_o, bp_upd_pc_o, bp_upd_target_o,
               bp_upd_taken_o, mispredict_cnt_o
    );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// Front-end PC redirect sequencer: arbitrates branch-mispredict and trap
// redirects, drains the in-flight ibus fetch, pulses the PC load and trains
// the branch predictor.
module fetch_redirect_ctrl #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fetch_redirect_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DRAIN, REDIRECT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bp_vld_q, bp_vld_d;
    logic [ADDR_W-1:0] bp_pc_q, bp_pc_d;
    logic [ADDR_W-1:0] bp_tgt_q, bp_tgt_d;
    logic              bp_tkn_q, bp_tkn_d;

    logic is_idle, mispredict, accept, resp_done;

    assign is_idle    = (state_q == IDLE);
    assign mispredict = bus.br_valid_i & ~bus.br_hit_i;
    // Gated by rst_n so the combinational outputs also read 0 while reset is held
    assign accept     = rst_n & is_idle & (bus.xcpt_valid_i | mispredict);
    assign resp_done  = ~bus.if_req_inflight_i | bus.if_resp_valid_i;

    // Next-state, redirect target, counter and predictor-update capture
    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        cnt_d    = cnt_q;
        bp_vld_d = 1'b0;
        bp_pc_d  = bp_pc_q;
        bp_tgt_d = bp_tgt_q;
        bp_tkn_d = bp_tkn_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    tgt_d   = bus.xcpt_valid_i ? bus.xcpt_target_i : bus.br_target_i;
                    state_d = resp_done ? REDIRECT : DRAIN;
                    if (!bus.xcpt_valid_i)
                        cnt_d = cnt_q + 1'b1;
                end
                if (bus.br_valid_i) begin
                    bp_vld_d = 1'b1;
                    bp_pc_d  = bus.br_pc_i;
                    bp_tgt_d = bus.br_target_i;
                    bp_tkn_d = bus.br_taken_i;
                end
            end
            DRAIN: begin
                if (bus.xcpt_valid_i)
                    tgt_d = bus.xcpt_target_i;
                if (bus.if_resp_valid_i)
                    state_d = REDIRECT;
            end
            REDIRECT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            tgt_q    <= '0;
            cnt_q    <= '0;
            bp_vld_q <= 1'b0;
            bp_pc_q  <= '0;
            bp_tgt_q <= '0;
            bp_tkn_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            cnt_q    <= cnt_d;
            bp_vld_q <= bp_vld_d;
            bp_pc_q  <= bp_pc_d;
            bp_tgt_q <= bp_tgt_d;
            bp_tkn_q <= bp_tkn_d;
        end
    end

    assign bus.pc_redirect_valid_o = (state_q == REDIRECT);
    assign bus.pc_redirect_o       = tgt_q;
    assign bus.stall_decode_o      = ~is_idle;
    assign bus.flush_fetch_o       = accept | ~is_idle;
    assign bus.drop_resp_o         = bus.if_resp_valid_i & (accept | (state_q == DRAIN));
    assign bus.bp_upd_valid_o      = bp_vld_q;
    assign bus.bp_upd_pc_o         = bp_pc_q;
    assign bus.bp_upd_target_o     = bp_tgt_q;
    assign bus.bp_upd_taken_o      = bp_tkn_q;
    assign bus.mispredict_cnt_o    = cnt_q;
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl; a second narrow-counter instance checks wrap.
module tb_fetch_redirect_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    fetch_redirect_ctrl_if #(.ADDR_W(64), .CNT_W(32)) bus ();
    fetch_redirect_ctrl_if #(.ADDR_W(64), .CNT_W(4))  bus_w ();

    fetch_redirect_ctrl #(.ADDR_W(64), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );
    fetch_redirect_ctrl #(.ADDR_W(64), .CNT_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .bus(bus_w.slave)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        bus.br_valid_i = 0; bus.br_hit_i = 0; bus.br_taken_i = 0;
        bus.br_pc_i = '0; bus.br_target_i = '0;
        bus.xcpt_valid_i = 0; bus.xcpt_target_i = '0;
        bus.if_req_inflight_i = 0; bus.if_resp_valid_i = 0;
    endtask

    task automatic br(input logic hit, input logic [63:0] pc, input logic [63:0] tgt);
        bus.br_valid_i = 1; bus.br_hit_i = hit; bus.br_taken_i = 1;
        bus.br_pc_i = pc; bus.br_target_i = tgt;
    endtask

    // Advance to 1 time unit after the next rising edge, then let inputs settle
    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        clr();
        bus_w.br_valid_i = 0; bus_w.br_hit_i = 0; bus_w.br_taken_i = 0;
        bus_w.br_pc_i = '0; bus_w.br_target_i = '0;
        bus_w.xcpt_valid_i = 0; bus_w.xcpt_target_i = '0;
        bus_w.if_req_inflight_i = 0; bus_w.if_resp_valid_i = 0;
        #12;
        chk("rst_redir_v", bus.pc_redirect_valid_o, 0);
        chk("rst_flush", bus.flush_fetch_o, 0);
        chk("rst_cnt", bus.mispredict_cnt_o, 0);
        chk("rst_pc", bus.pc_redirect_o, 0);
        rst_n = 1;
        tick();

        // Mispredict, no inflight fetch
        br(0, 64'h8000_0000, 64'h8000_0010); #1;
        chk("t1_flush_T", bus.flush_fetch_o, 1);
        chk("t1_redir_T", bus.pc_redirect_valid_o, 0);
        tick(); clr(); #1;
        chk("t1_redir_v", bus.pc_redirect_valid_o, 1);
        chk("t1_redir_pc", bus.pc_redirect_o, 64'h8000_0010);
        chk("t1_cnt", bus.mispredict_cnt_o, 1);
        chk("t1_bp_v", bus.bp_upd_valid_o, 1);
        chk("t1_bp_tgt", bus.bp_upd_target_o, 64'h8000_0010);
        chk("t1_bp_pc", bus.bp_upd_pc_o, 64'h8000_0000);
        chk("t1_flush_T1", bus.flush_fetch_o, 1);
        tick(); #1;
        chk("t1_redir_T2", bus.pc_redirect_valid_o, 0);
        chk("t1_bp_T2", bus.bp_upd_valid_o, 0);
        chk("t1_flush_T2", bus.flush_fetch_o, 0);
        chk("t1_stall_T2", bus.stall_decode_o, 0);

        // Drain: response arrives at T+3
        br(0, 64'h10, 64'h40); bus.if_req_inflight_i = 1; #1;
        chk("t2_drop_T", bus.drop_resp_o, 0);
        tick(); bus.br_valid_i = 0; #1;
        chk("t2_stall_T1", bus.stall_decode_o, 1);
        chk("t2_drop_T1", bus.drop_resp_o, 0);
        chk("t2_redir_T1", bus.pc_redirect_valid_o, 0);
        tick(); #1;
        chk("t2_stall_T2", bus.stall_decode_o, 1);
        chk("t2_flush_T2", bus.flush_fetch_o, 1);
        tick(); bus.if_resp_valid_i = 1; #1;
        chk("t2_drop_T3", bus.drop_resp_o, 1);
        chk("t2_redir_T3", bus.pc_redirect_valid_o, 0);
        tick(); clr(); #1;
        chk("t2_redir_T4", bus.pc_redirect_valid_o, 1);
        chk("t2_redir_pc", bus.pc_redirect_o, 64'h40);
        chk("t2_cnt", bus.mispredict_cnt_o, 2);
        tick();

        // Simultaneous branch mispredict and exception
        br(0, 64'h20, 64'h100);
        bus.xcpt_valid_i = 1; bus.xcpt_target_i = 64'h8000_0000;
        tick(); clr(); #1;
        chk("t3_redir_v", bus.pc_redirect_valid_o, 1);
        chk("t3_redir_pc", bus.pc_redirect_o, 64'h8000_0000);
        chk("t3_cnt", bus.mispredict_cnt_o, 2);
        chk("t3_bp_v", bus.bp_upd_valid_o, 1);
        chk("t3_bp_tgt", bus.bp_upd_target_o, 64'h100);
        tick();

        // Exception overrides target during DRAIN; wrong-path branch ignored
        br(0, 64'h30, 64'h200); bus.if_req_inflight_i = 1;
        tick();
        br(0, 64'h34, 64'h999);
        bus.xcpt_valid_i = 1; bus.xcpt_target_i = 64'h300; #1;
        chk("t4_bp_v_T1", bus.bp_upd_valid_o, 1);
        chk("t4_bp_tgt_T1", bus.bp_upd_target_o, 64'h200);
        tick();
        bus.br_valid_i = 0; bus.xcpt_valid_i = 0; bus.if_resp_valid_i = 1; #1;
        chk("t4_bp_v_wrongpath", bus.bp_upd_valid_o, 0);
        chk("t4_drop", bus.drop_resp_o, 1);
        chk("t4_cnt", bus.mispredict_cnt_o, 3);
        tick(); clr(); #1;
        chk("t4_redir_v", bus.pc_redirect_valid_o, 1);
        chk("t4_redir_pc", bus.pc_redirect_o, 64'h300);
        tick();

        // Correct prediction
        br(1, 64'h40, 64'h501); #1;
        chk("t5_flush_T", bus.flush_fetch_o, 0);
        tick(); clr(); #1;
        chk("t5_redir_v", bus.pc_redirect_valid_o, 0);
        chk("t5_bp_v", bus.bp_upd_valid_o, 1);
        chk("t5_bp_tgt", bus.bp_upd_target_o, 64'h501);
        chk("t5_bp_tkn", bus.bp_upd_taken_o, 1);
        chk("t5_cnt", bus.mispredict_cnt_o, 3);
        chk("t5_stall", bus.stall_decode_o, 0);

        // Reset while draining
        br(0, 64'h50, 64'h600); bus.if_req_inflight_i = 1;
        tick(); bus.br_valid_i = 0; #1;
        chk("t6_stall_drain", bus.stall_decode_o, 1);
        rst_n = 0; bus.if_resp_valid_i = 1; #1;
        chk("t6_rst_stall", bus.stall_decode_o, 0);
        chk("t6_rst_flush", bus.flush_fetch_o, 0);
        chk("t6_rst_drop", bus.drop_resp_o, 0);
        chk("t6_rst_pc", bus.pc_redirect_o, 0);
        chk("t6_rst_cnt", bus.mispredict_cnt_o, 0);
        chk("t6_rst_bp_v", bus.bp_upd_valid_o, 0);
        tick(); rst_n = 1; #1;
        chk("t6_post_drop", bus.drop_resp_o, 0);
        tick(); clr(); #1;
        chk("t6_post_redir", bus.pc_redirect_valid_o, 0);
        chk("t6_post_stall", bus.stall_decode_o, 0);

        // Counter wrap on the 4-bit instance: 16 mispredicts return to 0
        for (int i = 0; i < 16; i++) begin
            bus_w.br_valid_i = 1; bus_w.br_hit_i = 0; bus_w.br_target_i = 64'h1000;
            tick();
            bus_w.br_valid_i = 0;
            tick();
            if (i == 14) chk("t7_cnt_max", bus_w.mispredict_cnt_o, 15);
        end
        #1;
        chk("t7_cnt_wrap", bus_w.mispredict_cnt_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_redirect_ctrl.md
# fetch_redirect_ctrl

Sequences front-end PC redirection after branch resolution in decode and after traps from commit. It arbitrates the two redirect sources and drains or discards the in-flight instruction-bus fetch. It then issues a single-cycle redirect to the PC register and emits one predictor-training update per resolved branch. It sits between the decode-stage branch resolver, the commit/trap logic, and the fetch stage / PC register.

## Interface
- ADDR_W, 64, width of all PC/target fields
- CNT_W, 32, width of mispredict counter
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; asserted (0) forces reset state immediately
- br_valid  in  1  decode resolved a control-flow instruction this cycle
- br_hit  in  1  prediction matched resolution (valid with br_valid)
- br_taken  in  1  resolved direction, 1 = PCJUMP
- br_pc  in  ADDR_W  PC of resolved instruction
- br_target  in  ADDR_W  resolved next PC (PC+4 or jump target)
- xcpt_valid  in  1  commit requests trap redirect this cycle
- xcpt_target  in  ADDR_W  trap vector
- if_req_inflight  in  1  fetch has an outstanding ibus request
- if_resp_valid  in  1  ibus response returns this cycle
- pc_redirect_valid  out  1  one-cycle pulse: load pc_redirect into PC
- pc_redirect  out  ADDR_W  redirect address
- flush_fetch  out  1  invalidate F/D register contents
- drop_resp  out  1  discard ibus response this cycle
- stall_decode  out  1  hold decode (no new resolutions)
- bp_upd_valid  out  1  predictor update pulse
- bp_upd_pc / bp_upd_target  out  ADDR_W  registered br_pc / br_target
- bp_upd_taken  out  1  registered br_taken
- mispredict_cnt  out  CNT_W  accepted branch mispredicts

## Operation
- States: IDLE, DRAIN, REDIRECT.
- Accept event in IDLE: xcpt_valid, or (br_valid & ~br_hit).
  - If both occur in the same cycle, the exception wins and the branch is not counted.
  - The winning target is latched into tgt_q.
- IDLE -> REDIRECT on accept when the inflight response is finished: if_req_inflight=0, or if_resp_valid=1 in the same cycle.
- IDLE -> DRAIN on accept when if_req_inflight=1 and if_resp_valid=0.
- DRAIN -> REDIRECT on if_resp_valid.
- DRAIN, xcpt_valid: tgt_q overwritten by xcpt_target; state is unchanged unless if_resp_valid is also set.
- DRAIN, br_valid: ignored (wrong-path). No counter change, no bp update.
- REDIRECT -> IDLE unconditionally after one cycle.
- REDIRECT, xcpt_valid: treated as a new accept in IDLE on the following cycle. The exception is held by the commit source.
- pc_redirect_valid = (state==REDIRECT); pc_redirect = tgt_q. Bit 0 is passed unchanged (no masking).
- flush_fetch is asserted combinationally in the accept cycle, and through all of DRAIN and REDIRECT.
- stall_decode = (state != IDLE).
- drop_resp = if_resp_valid & (accept cycle | state==DRAIN).
- bp update: every br_valid in IDLE (hit or miss), including a branch that loses to a same-cycle exception, is registered. bp_upd_* are valid the next cycle for exactly one cycle.
- mispredict_cnt increments by 1 per accepted branch mispredict. It wraps from 2^CNT_W-1 to 0.
- Reset: state=IDLE; tgt_q=0; counter=0; all outputs 0. Reset mid-DRAIN/REDIRECT abandons the redirect with no pulse.

## Timing
- The accept cycle is T.
- No inflight request: pc_redirect_valid at T+1, back to IDLE at T+2. Redirect latency is 1 cycle.
- Inflight request, response at T+k (k≥1): drop_resp at T+k, pc_redirect_valid at T+k+1.
- flush_fetch is high from T through the redirect cycle inclusive.
- bp_upd_valid is high at T+1 for the resolution at T.
- Outputs are registered except flush_fetch and drop_resp, which are combinational from inputs plus state.
- Back-to-back: a new accept is possible in the cycle after REDIRECT (IDLE). Minimum redirect spacing is 2 cycles.

## Test plan
- Mispredict with no inflight request: br_valid=1, br_hit=0, br_target=0x8000_0010 at T.
  - Required: flush_fetch=1 at T; pc_redirect_valid=1 with pc_redirect=0x8000_0010 at T+1 only; mispredict_cnt=1; bp_upd_valid at T+1 with target 0x8000_0010.
- Drain: accept at T with if_req_inflight=1, if_resp_valid at T+3.
  - Required: DRAIN for T+1..T+3; stall_decode=1; drop_resp=1 only at T+3; redirect pulse at T+4.
- Simultaneous: br mispredict to 0x100 and xcpt_target=0x8000_0000 in the same cycle.
  - Required: redirect to 0x8000_0000; counter unchanged; bp_upd_valid still pulses for the branch.
- Exception overrides during DRAIN: branch to 0x200 accepted, then xcpt 0x300 one cycle later, response arrives after that.
  - Required: redirect to 0x300; the wrong-path br_valid seen in DRAIN produces no update.
- Correct prediction: br_valid=1, br_hit=1.
  - Required: no flush, no redirect, bp_upd_valid pulse, counter unchanged.
- Reset and wrap:
  - Reset=0 while in DRAIN: all outputs 0 immediately; no redirect after release.
  - Counter preloaded to 0xFFFF_FFFF plus one mispredict: reads 0.
